// File: rtl/my9262_frame_ctrl.sv
// my9262_frame_ctrl: walks the frame RAM in MY9262 cascade order and hands each
// grayscale word plus its latch tag to the serial shift engine.
module my9262_frame_ctrl #(
  parameter int unsigned CHIPS  = 4,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned TMO    = 1023
) (
  input  logic              CLK_60M,
  input  logic              RST_N,
  input  logic              enable,
  input  logic              frame_start,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd,
  input  logic [15:0]       ram_rdata,
  output logic [15:0]       sh_data,
  output logic [1:0]        sh_lat_mode,
  output logic              sh_start,
  input  logic              sh_busy,
  input  logic              sh_done,
  output logic              frame_busy,
  output logic              frame_done,
  output logic              overrun,
  output logic              tmo_err
);
  typedef enum logic [2:0] {IDLE, FETCH, RDWAIT, ISSUE, WAITDONE, FINISH} state_t;
  localparam logic [3:0] CHIP_MAX = 4'(CHIPS - 1);
  localparam logic [9:0] TMO_LAST = 10'(TMO - 1);
  state_t     state;
  logic [3:0] ch, chip, ch_nxt, chip_nxt;
  logic [9:0] tmo_cnt;
  logic       pending, last;
  always_comb begin
    last     = chip == 4'd0 && ch == 4'd0;
    chip_nxt = chip == 4'd0 ? CHIP_MAX : chip - 4'd1;
    ch_nxt   = chip == 4'd0 ? ch - 4'd1 : ch;
  end
  always_ff @(posedge CLK_60M or negedge RST_N) begin
    if (!RST_N) begin
      state       <= IDLE;
      ch          <= '0;
      chip        <= '0;
      tmo_cnt     <= '0;
      pending     <= 1'b0;
      ram_addr    <= '0;
      ram_rd      <= 1'b0;
      sh_data     <= '0;
      sh_lat_mode <= '0;
      sh_start    <= 1'b0;
      frame_busy  <= 1'b0;
      frame_done  <= 1'b0;
      overrun     <= 1'b0;
      tmo_err     <= 1'b0;
    end else begin
      ram_rd     <= 1'b0;
      sh_start   <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      tmo_err    <= 1'b0;
      // one request may queue behind a running frame; a second one is dropped
      if (frame_start && state != IDLE) begin
        if (pending) overrun <= 1'b1;
        else pending <= 1'b1;
      end
      case (state)
        IDLE: begin
          if ((frame_start || pending) && enable) begin
            ch         <= 4'd15;
            chip       <= CHIP_MAX;
            pending    <= 1'b0;
            ram_addr   <= ADDR_W'({CHIP_MAX, 4'd15});
            ram_rd     <= 1'b1;
            frame_busy <= 1'b1;
            state      <= FETCH;
          end
        end
        FETCH: state <= RDWAIT;
        RDWAIT: begin
          sh_data     <= ram_rdata;
          sh_lat_mode <= chip != 4'd0 ? 2'd0 : ch != 4'd0 ? 2'd1 : 2'd2;
          state       <= ISSUE;
        end
        ISSUE: begin
          if (!sh_busy) begin
            sh_start <= 1'b1;
            tmo_cnt  <= '0;
            state    <= WAITDONE;
          end
        end
        WAITDONE: begin
          if (sh_done) begin
            if (last) begin
              frame_done <= 1'b1;
              state      <= FINISH;
            end else begin
              ch       <= ch_nxt;
              chip     <= chip_nxt;
              ram_addr <= ADDR_W'({chip_nxt, ch_nxt});
              ram_rd   <= 1'b1;
              state    <= FETCH;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            tmo_err    <= 1'b1;
            frame_busy <= 1'b0;
            state      <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 10'd1;
          end
        end
        FINISH: begin
          frame_busy <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_my9262_frame_ctrl.sv
// tb_my9262_frame_ctrl: directed scenarios with random RAM contents and engine
// timing, checked against a word-order model built from the frame rules.
module tb_my9262_frame_ctrl;
  logic        CLK_60M = 1'b0, RST_N = 1'b0, enable = 1'b1, frame_start = 1'b0;
  logic [7:0]  ram_addr;
  logic        ram_rd, sh_start, frame_busy, frame_done, overrun, tmo_err;
  logic [15:0] ram_rdata = '0, sh_data;
  logic [1:0]  sh_lat_mode;
  logic        sh_busy = 1'b0, sh_done = 1'b0;

  my9262_frame_ctrl #(.CHIPS(4), .ADDR_W(8), .TMO(50)) dut (
    .CLK_60M(CLK_60M), .RST_N(RST_N), .enable(enable), .frame_start(frame_start),
    .ram_addr(ram_addr), .ram_rd(ram_rd), .ram_rdata(ram_rdata), .sh_data(sh_data),
    .sh_lat_mode(sh_lat_mode), .sh_start(sh_start), .sh_busy(sh_busy), .sh_done(sh_done),
    .frame_busy(frame_busy), .frame_done(frame_done), .overrun(overrun), .tmo_err(tmo_err)
  );

  always #5 CLK_60M = ~CLK_60M;

  int total = 0, bad = 0, cyc = 0;
  logic [15:0] mem [256];
  int exp_addr [64], exp_lat [64];
  int addr_q [$], data_q [$], lat_q [$];
  int abase = 0, dbase = 0, wbase = 0;
  int busy_len = 34, hold_word = 0, drop_word = 0;
  int nstart = 0, rel, bcnt = 0, hcnt = 0, viol = 0, gap = 0, last_done = 0, drop_cyc = 0;
  int done_cnt = 0, ovr_n = 0, tmo_n = 0, tmo_cyc = 0;

  always @(posedge CLK_60M) begin
    cyc++;
    ram_rdata <= ram_rd ? mem[ram_addr] : 16'($urandom);
  end

  always @(negedge CLK_60M) begin
    if (ram_rd) addr_q.push_back(int'(ram_addr));
    if (frame_done) done_cnt++;
    if (overrun) ovr_n++;
    if (tmo_err) begin tmo_n++; tmo_cyc = cyc; end
  end

  // shift engine: busy for busy_len cycles per word, optional extra hold or lost sh_done
  always @(negedge CLK_60M or negedge RST_N) begin
    if (!RST_N) begin
      sh_busy = 1'b0; sh_done = 1'b0; bcnt = 0; hcnt = 0;
    end else begin
      if (sh_start && sh_busy) viol++;
      sh_done = 1'b0;
      if (sh_start) begin
        nstart++;
        rel = nstart - wbase;
        data_q.push_back(int'(sh_data));
        lat_q.push_back(int'(sh_lat_mode));
        if (rel == hold_word) gap = cyc - last_done;
        if (rel == drop_word) drop_cyc = cyc;
        else bcnt = busy_len;
      end else if (bcnt > 0) begin
        bcnt--;
        if (bcnt == 0) begin
          sh_done = 1'b1;
          last_done = cyc;
          if (nstart - wbase == hold_word - 1) hcnt = 200;
        end
      end else if (hcnt > 0) hcnt--;
      sh_busy = bcnt > 0 || hcnt > 0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_seq(input string tag, input int nw);
    chk({tag, "_reads"}, 64'(addr_q.size() - abase), 64'(nw));
    chk({tag, "_starts"}, 64'(data_q.size() - dbase), 64'(nw));
    for (int k = 0; k < nw; k++) begin
      if (abase + k < addr_q.size())
        chk($sformatf("%s_addr%0d", tag, k), 64'(addr_q[abase + k]), 64'(exp_addr[k % 64]));
      if (dbase + k < data_q.size()) begin
        chk($sformatf("%s_data%0d", tag, k), 64'(data_q[dbase + k]), 64'(mem[exp_addr[k % 64]]));
        chk($sformatf("%s_lat%0d", tag, k), 64'(lat_q[dbase + k]), 64'(exp_lat[k % 64]));
      end
    end
    abase = addr_q.size();
    dbase = data_q.size();
  endtask

  task automatic wait_cnt(input int sel, input int target, input string tag);
    int n = 0;
    while ((sel == 0 ? done_cnt : sel == 1 ? nstart : tmo_n) < target && n < 20000) begin
      @(negedge CLK_60M);
      n++;
    end
    chk({tag, "_reached"}, 64'((sel == 0 ? done_cnt : sel == 1 ? nstart : tmo_n) >= target), 64'd1);
  endtask

  task automatic pulse();
    @(negedge CLK_60M) frame_start = 1'b1;
    @(negedge CLK_60M) frame_start = 1'b0;
  endtask

  function automatic logic [31:0] outs();
    return {ram_addr, ram_rd, sh_data, sh_lat_mode, sh_start, frame_busy, frame_done, overrun, tmo_err};
  endfunction

  initial begin
    int t, o, n, d;
    n = 0;
    for (int c = 15; c >= 0; c--)
      for (int p = 3; p >= 0; p--) begin
        exp_addr[n] = p * 16 + c;
        exp_lat[n] = p != 0 ? 0 : c != 0 ? 1 : 2;
        n++;
      end
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    repeat (3) @(negedge CLK_60M);
    chk("reset_outs", 64'(outs()), 64'd0);
    RST_N = 1'b1;
    repeat (3) @(negedge CLK_60M);
    chk("idle_outs", 64'(outs()), 64'd0);

    // single frame with the nominal 34-cycle engine
    wbase = nstart; t = done_cnt + 1;
    pulse();
    wait_cnt(0, t, "s1");
    repeat (20) @(negedge CLK_60M);
    chk("s1_done_once", 64'(done_cnt), 64'(t));
    chk("s1_idle", 64'(frame_busy), 64'd0);
    check_seq("s1", 64);

    // two queued requests: one pending, one dropped with overrun
    busy_len = $urandom_range(20, 40);
    wbase = nstart; t = done_cnt + 2; o = ovr_n;
    pulse();
    repeat ($urandom_range(50, 300)) @(negedge CLK_60M);
    pulse();
    repeat ($urandom_range(50, 300)) @(negedge CLK_60M);
    pulse();
    wait_cnt(0, t, "s2");
    repeat (50) @(negedge CLK_60M);
    chk("s2_frames", 64'(done_cnt), 64'(t));
    chk("s2_overrun", 64'(ovr_n), 64'(o + 1));
    check_seq("s2", 128);

    // request arriving in the FINISH cycle restarts right after one IDLE cycle
    wbase = nstart; t = done_cnt + 2; n = 0;
    pulse();
    while (!frame_done && n < 20000) begin @(negedge CLK_60M); n++; end
    chk("s3_finish_seen", 64'(frame_done), 64'd1);
    frame_start = 1'b1;
    @(negedge CLK_60M) frame_start = 1'b0;
    chk("s3_idle_busy", 64'(frame_busy), 64'd0);
    chk("s3_idle_rd", 64'(ram_rd), 64'd0);
    @(negedge CLK_60M);
    chk("s3_restart_busy", 64'(frame_busy), 64'd1);
    chk("s3_restart_rd", 64'(ram_rd), 64'd1);
    chk("s3_restart_addr", 64'(ram_addr), 64'd63);
    wait_cnt(0, t, "s3");
    repeat (20) @(negedge CLK_60M);
    check_seq("s3", 128);

    // engine stays busy 200 extra cycles before word 5
    busy_len = 34;
    wbase = nstart; t = done_cnt + 1; hold_word = 5;
    pulse();
    wait_cnt(0, t, "s4");
    hold_word = 0;
    repeat (20) @(negedge CLK_60M);
    chk("s4_gap_ok", 64'(gap >= 200 && gap <= 202), 64'd1);
    chk("s4_no_start_while_busy", 64'(viol), 64'd0);
    check_seq("s4", 64);

    // sh_done lost on word 10: timeout after 50 cycles, frame abandoned
    wbase = nstart; d = done_cnt; drop_word = 10;
    pulse();
    wait_cnt(2, tmo_n + 1, "s5_tmo");
    drop_word = 0;
    chk("s5_tmo_latency", 64'(tmo_cyc - drop_cyc), 64'd50);
    repeat (10) @(negedge CLK_60M);
    chk("s5_idle", 64'(frame_busy), 64'd0);
    chk("s5_no_done", 64'(done_cnt), 64'(d));
    check_seq("s5_part", 10);
    wbase = nstart; t = done_cnt + 1;
    pulse();
    wait_cnt(0, t, "s5b");
    repeat (20) @(negedge CLK_60M);
    check_seq("s5_full", 64);

    // pending request held while enable is low, served when it returns
    wbase = nstart; t = done_cnt + 1;
    pulse();
    repeat ($urandom_range(100, 400)) @(negedge CLK_60M);
    pulse();
    enable = 1'b0;
    wait_cnt(0, t, "s6a");
    repeat (50) @(negedge CLK_60M);
    chk("s6_hold_idle", 64'(frame_busy), 64'd0);
    o = ovr_n;
    pulse();
    repeat (50) @(negedge CLK_60M);
    chk("s6_ignored_idle", 64'(frame_busy), 64'd0);
    chk("s6_no_overrun", 64'(ovr_n), 64'(o));
    check_seq("s6a", 64);
    t = done_cnt + 1;
    enable = 1'b1;
    wait_cnt(0, t, "s6b");
    repeat (100) @(negedge CLK_60M);
    chk("s6_single_frame", 64'(done_cnt), 64'(t));
    check_seq("s6b", 64);

    // async reset during word 20 clears outputs and the pending request
    wbase = nstart; d = done_cnt;
    pulse();
    repeat (30) @(negedge CLK_60M);
    pulse();
    wait_cnt(1, wbase + 20, "s7_w20");
    #2 RST_N = 1'b0;
    #1 chk("s7_async_outs", 64'(outs()), 64'd0);
    repeat (2) @(negedge CLK_60M);
    RST_N = 1'b1;
    repeat (30) @(negedge CLK_60M);
    chk("s7_pending_cleared", 64'(frame_busy), 64'd0);
    chk("s7_no_done", 64'(done_cnt), 64'(d));
    check_seq("s7_part", 20);
    wbase = nstart; t = done_cnt + 1;
    pulse();
    wait_cnt(0, t, "s7b");
    repeat (20) @(negedge CLK_60M);
    check_seq("s7_full", 64);
    chk("end_no_start_while_busy", 64'(viol), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
